// File: rtl/ex_stage_pkg.sv
// EXMEM_pkg: ID/EX and EX/MEM pipeline records plus the ALU op codes
// shared by decode and the execute stage (ex_alu, ex_stage).
package EXMEM_pkg;

   localparam int EX_XLEN = 32;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLL   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_SLT   = 4'd8;
   localparam logic [3:0] ALU_SLTU  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef struct packed {
      logic [EX_XLEN-1:0] pc;
      logic [EX_XLEN-1:0] rs1_val;
      logic [EX_XLEN-1:0] rs2_val;
      logic [EX_XLEN-1:0] imm;
      logic [4:0]         rd;
      logic [3:0]         alu_op;
      logic               alu_src;
      logic               branch;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic               valid;
   } id_ex_t;

   typedef struct packed {
      logic [EX_XLEN-1:0] pc;
      logic [EX_XLEN-1:0] alu_result;
      logic [EX_XLEN-1:0] rs2_val;
      logic [4:0]         rd;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic               valid;
   } ex_mem_t;

endpackage

// File: rtl/ex_stage_alu.sv
// ex_alu: combinational ALU, (i_op_a, i_op_b, i_alu_op) -> o_result.
// Ports: i_op_a/i_op_b operands, i_alu_op code, o_result XLEN result.
module ex_alu
   import EXMEM_pkg::*;
#(
   parameter int XLEN = EX_XLEN
) (
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic [3:0]      i_alu_op,
   output logic [XLEN-1:0] o_result
);

   logic [4:0] w_shamt;
   logic       w_lt_s;
   logic       w_lt_u;

   assign w_shamt = i_op_b[4:0];
   assign w_lt_s  = $signed(i_op_a) < $signed(i_op_b);
   assign w_lt_u  = i_op_a < i_op_b;

   always_comb begin
      o_result = '0;
      unique case (i_alu_op)
         ALU_ADD:   o_result = i_op_a + i_op_b;
         ALU_SUB:   o_result = i_op_a - i_op_b;
         ALU_AND:   o_result = i_op_a & i_op_b;
         ALU_OR:    o_result = i_op_a | i_op_b;
         ALU_XOR:   o_result = i_op_a ^ i_op_b;
         ALU_SLL:   o_result = i_op_a << w_shamt;
         ALU_SRL:   o_result = i_op_a >> w_shamt;
         ALU_SRA:   o_result = $unsigned($signed(i_op_a) >>> w_shamt);
         ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, w_lt_s};
         ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, w_lt_u};
         ALU_PASSB: o_result = i_op_b;
         default:   o_result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage; forwards operands, runs ex_alu, resolves
// branches, registers EX/MEM and squashes one wrong-path instruction.
// Ports: clk/rst (sync, active-high), id_ex_i record, stall_i/ex_ready_o,
// rs1/rs2_idx_i + wb_* forwarding sources, ex_mem_o, redirect_*_o.
// Macro EX_FWD_EN enables forwarding; when undefined the operands come
// straight from id_ex_i and the idx/wb inputs are ignored.
module ex_stage
   import EXMEM_pkg::*;
#(
   parameter int XLEN = EX_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  id_ex_t          id_ex_i,
   input  logic            stall_i,
   output logic            ex_ready_o,
   input  logic [4:0]      rs1_idx_i,
   input  logic [4:0]      rs2_idx_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            wb_we_i,
   output ex_mem_t         ex_mem_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   ex_mem_t         r_ex_mem;
   logic            r_squash;
   logic            r_redir_v;
   logic [XLEN-1:0] r_redir_pc;

   logic [XLEN-1:0] w_rs1;
   logic [XLEN-1:0] w_rs2;
   logic [XLEN-1:0] w_op_b;
   logic [XLEN-1:0] w_alu;
   logic [XLEN-1:0] w_target;
   logic            w_v;
   logic            w_taken;
   ex_mem_t         w_next;

`ifdef EX_FWD_EN
   logic w_mem_ok;
   logic w_wb_ok;

   // loads in EX/MEM have no data yet, so they never forward
   assign w_mem_ok = r_ex_mem.valid & r_ex_mem.reg_write
                   & ~r_ex_mem.mem_to_reg
                   & (r_ex_mem.rd != 5'd0);
   assign w_wb_ok  = wb_we_i & (wb_rd_i != 5'd0);

   always_comb begin
      w_rs1 = id_ex_i.rs1_val;
      if (w_mem_ok && (r_ex_mem.rd == rs1_idx_i))
         w_rs1 = r_ex_mem.alu_result;
      else if (w_wb_ok && (wb_rd_i == rs1_idx_i))
         w_rs1 = wb_data_i;
   end

   always_comb begin
      w_rs2 = id_ex_i.rs2_val;
      if (w_mem_ok && (r_ex_mem.rd == rs2_idx_i))
         w_rs2 = r_ex_mem.alu_result;
      else if (w_wb_ok && (wb_rd_i == rs2_idx_i))
         w_rs2 = wb_data_i;
   end
`else
   logic w_unused_fwd;

   assign w_rs1 = id_ex_i.rs1_val;
   assign w_rs2 = id_ex_i.rs2_val;
   assign w_unused_fwd = ^{rs1_idx_i, rs2_idx_i,
                           wb_rd_i, wb_data_i, wb_we_i};
`endif

   assign w_op_b   = id_ex_i.alu_src ? id_ex_i.imm : w_rs2;
   assign w_v      = id_ex_i.valid & ~r_squash;
   assign w_taken  = w_v & id_ex_i.branch & (w_rs1 == w_rs2);
   assign w_target = id_ex_i.pc + id_ex_i.imm;

   ex_alu #(
      .XLEN(XLEN)
   ) u_alu (
      .i_op_a  (w_rs1),
      .i_op_b  (w_op_b),
      .i_alu_op(id_ex_i.alu_op),
      .o_result(w_alu)
   );

   // data fields load even for bubbles; only the controls are gated
   always_comb begin
      w_next            = '0;
      w_next.pc         = id_ex_i.pc;
      w_next.alu_result = w_alu;
      w_next.rs2_val    = w_rs2;
      w_next.rd         = id_ex_i.rd;
      w_next.mem_read   = id_ex_i.mem_read & w_v;
      w_next.mem_write  = id_ex_i.mem_write & w_v;
      w_next.reg_write  = id_ex_i.reg_write & w_v;
      w_next.mem_to_reg = id_ex_i.mem_to_reg & w_v;
      w_next.valid      = w_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_mem   <= '0;
         r_squash   <= 1'b0;
         r_redir_v  <= 1'b0;
         r_redir_pc <= '0;
      end else begin
         // the pulse drops after one cycle even under stall
         r_redir_v <= 1'b0;
         if (!stall_i) begin
            r_ex_mem  <= w_next;
            r_squash  <= w_taken;
            r_redir_v <= w_taken;
            if (w_taken)
               r_redir_pc <= w_target;
         end
      end
   end

   assign ex_ready_o       = ~stall_i;
   assign ex_mem_o         = r_ex_mem;
   assign redirect_valid_o = r_redir_v;
   assign redirect_pc_o    = r_redir_pc;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage, checked every cycle against
// a behavioural model plus hand-computed literal expectations.
module tb_ex_stage;
   import EXMEM_pkg::*;

`ifdef EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   id_ex_t      ie;
   logic        stall;
   logic        ready;
   logic [4:0]  rs1_idx, rs2_idx, wb_rd;
   logic [31:0] wb_data;
   logic        wb_we;
   ex_mem_t     em;
   logic        rv;
   logic [31:0] rpc;

   int n_chk  = 0;
   int n_pass = 0;

   ex_stage #(.XLEN(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_ex_i         (ie),
      .stall_i         (stall),
      .ex_ready_o      (ready),
      .rs1_idx_i       (rs1_idx),
      .rs2_idx_i       (rs2_idx),
      .wb_rd_i         (wb_rd),
      .wb_data_i       (wb_data),
      .wb_we_i         (wb_we),
      .ex_mem_o        (em),
      .redirect_valid_o(rv),
      .redirect_pc_o   (rpc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      sh = b[4:0];
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return (a >> sh) |
                       (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))
                       ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   ex_mem_t     m_mem;
   logic        m_rv  = 1'b0;
   logic [31:0] m_rpc = '0;
   logic        m_sq  = 1'b0;
   logic        m_started = 1'b0;

   function automatic logic [31:0] fwd(input logic [4:0] idx,
                                       input logic [31:0] raw);
      if (!FWD || idx == 5'd0) return raw;
      if (m_mem.valid && m_mem.reg_write && !m_mem.mem_to_reg &&
          m_mem.rd == idx)
         return m_mem.alu_result;
      if (wb_we && wb_rd == idx) return wb_data;
      return raw;
   endfunction

   always @(posedge clk) begin
      ex_mem_t     nm;
      logic [31:0] a, b, ob;
      logic        v, tk;
      m_started = 1'b1;
      if (rst) begin
         m_mem = '0;
         m_rv  = 1'b0;
         m_rpc = '0;
         m_sq  = 1'b0;
      end else if (stall) begin
         m_rv = 1'b0;
      end else begin
         v  = ie.valid && !m_sq;
         a  = fwd(rs1_idx, ie.rs1_val);
         b  = fwd(rs2_idx, ie.rs2_val);
         ob = ie.alu_src ? ie.imm : b;
         tk = v && ie.branch && (a == b);
         nm = '0;
         if (v) begin
            nm.pc         = ie.pc;
            nm.alu_result = ref_alu(ie.alu_op, a, ob);
            nm.rs2_val    = b;
            nm.rd         = ie.rd;
            nm.mem_read   = ie.mem_read;
            nm.mem_write  = ie.mem_write;
            nm.reg_write  = ie.reg_write;
            nm.mem_to_reg = ie.mem_to_reg;
            nm.valid      = 1'b1;
         end
         m_mem = nm;
         m_rv  = tk;
         m_sq  = tk;
         if (tk) m_rpc = ie.pc + ie.imm;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("ready", 32'(ready), 32'(!stall));
         chk("valid", 32'(em.valid), 32'(m_mem.valid));
         chk("reg_write", 32'(em.reg_write), 32'(m_mem.reg_write));
         chk("mem_read", 32'(em.mem_read), 32'(m_mem.mem_read));
         chk("mem_write", 32'(em.mem_write), 32'(m_mem.mem_write));
         chk("mem_to_reg", 32'(em.mem_to_reg), 32'(m_mem.mem_to_reg));
         chk("redir_v", 32'(rv), 32'(m_rv));
         chk("redir_pc", rpc, m_rpc);
         if (m_mem.valid) begin
            chk("alu_result", em.alu_result, m_mem.alu_result);
            chk("rs2_val", em.rs2_val, m_mem.rs2_val);
            chk("rd", 32'(em.rd), 32'(m_mem.rd));
            chk("pc", em.pc, m_mem.pc);
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic id_ex_t mk(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [4:0] rd);
      id_ex_t r;
      r           = '0;
      r.valid     = 1'b1;
      r.reg_write = 1'b1;
      r.alu_op    = op;
      r.rs1_val   = a;
      r.rs2_val   = b;
      r.rd        = rd;
      r.pc        = 32'h1000;
      return r;
   endfunction

   function automatic id_ex_t mkbr(input logic [31:0] pc,
                                   input logic [31:0] imm,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
      id_ex_t r;
      r           = mk(ALU_ADD, a, b, 5'd0);
      r.reg_write = 1'b0;
      r.branch    = 1'b1;
      r.pc        = pc;
      r.imm       = imm;
      return r;
   endfunction

   task automatic go(input id_ex_t r, input logic st);
      ie    = r;
      stall = st;
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  t_op  [0:10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                 4'd6, 4'd8, 4'd9, 4'd10, 4'd15};
   logic [31:0] t_a   [0:10] = '{32'hFFFF_FFFF, 32'd3, 32'hF0F0,
                                 32'hF0F0, 32'hF0F0, 32'd1,
                                 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd0, 32'd7};
   logic [31:0] t_b   [0:10] = '{32'd2, 32'd5, 32'hFF00, 32'hFF00,
                                 32'hFF00, 32'h3F, 32'd31, 32'd1,
                                 32'd1, 32'hABCD, 32'd9};
   logic [31:0] t_exp [0:10] = '{32'd1, 32'hFFFF_FFFE, 32'hF000,
                                 32'hFFF0, 32'h0FF0, 32'h8000_0000,
                                 32'd1, 32'd1, 32'd0, 32'hABCD, 32'd0};

   initial begin
      id_ex_t r, g;
      rst = 1'b1;
      ie = '0;
      stall = 1'b0;
      rs1_idx = '0;
      rs2_idx = '0;
      wb_rd = '0;
      wb_data = '0;
      wb_we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_alu", em.alu_result, 32'd0);
      chk("rst_pc", em.pc, 32'd0);
      chk("rst_rs2", em.rs2_val, 32'd0);
      chk("rst_ctl", 32'({em.rd, em.mem_read, em.mem_write,
                          em.reg_write, em.mem_to_reg, em.valid}), 32'd0);
      chk("rst_rv", 32'(rv), 32'd0);
      rst = 1'b0;

      go(mk(ALU_ADD, 32'd5, 32'd7, 5'd1), 1'b0);
      chk("add_5_7", em.alu_result, 32'd12);
      chk("add_valid", 32'(em.valid), 32'd1);

      // EX/MEM forward of x3
      go(mk(ALU_ADD, 32'h10, 32'd0, 5'd3), 1'b0);
      rs1_idx = 5'd3;
      rs2_idx = 5'd3;
      go(mk(ALU_ADD, 32'd0, 32'd0, 5'd4), 1'b0);
      chk("fwd_exmem", em.alu_result, FWD ? 32'h20 : 32'h0);
      rs1_idx = '0;
      rs2_idx = '0;

      // EX/MEM beats WB; load in EX/MEM falls back to WB
      go(mk(ALU_ADD, 32'd1, 32'd0, 5'd5), 1'b0);
      rs1_idx = 5'd5;
      wb_rd = 5'd5;
      wb_data = 32'd9;
      wb_we = 1'b1;
      go(mk(ALU_ADD, 32'd0, 32'd0, 5'd7), 1'b0);
      chk("fwd_prio", em.alu_result, FWD ? 32'd1 : 32'd0);
      rs1_idx = '0;
      r = mk(ALU_ADD, 32'h40, 32'd0, 5'd5);
      r.mem_read = 1'b1;
      r.mem_to_reg = 1'b1;
      go(r, 1'b0);
      rs1_idx = 5'd5;
      go(mk(ALU_ADD, 32'd0, 32'd0, 5'd8), 1'b0);
      chk("fwd_load_wb", em.alu_result, FWD ? 32'd9 : 32'd0);
      rs1_idx = '0;
      wb_rd = '0;
      wb_data = '0;
      wb_we = 1'b0;

      // taken branch and its squash
      g = mk(ALU_ADD, 32'd1, 32'd1, 5'd9);
      go(mkbr(32'h100, 32'h20, 32'd4, 32'd4), 1'b0);
      chk("br_rv", 32'(rv), 32'd1);
      chk("br_rpc", rpc, 32'h120);
      go(g, 1'b0);
      chk("sq_valid", 32'(em.valid), 32'd0);
      chk("sq_rw", 32'(em.reg_write), 32'd0);
      chk("br_rv_pulse", 32'(rv), 32'd0);
      go(mkbr(32'h200, 32'h8, 32'd4, 32'd5), 1'b0);
      chk("nt_rv", 32'(rv), 32'd0);
      go(mk(ALU_ADD, 32'd2, 32'd2, 5'd10), 1'b0);
      chk("nt_next", em.alu_result, 32'd4);

      // stall holds EX/MEM
      r = mk(ALU_ADD, 32'd2, 32'd3, 5'd6);
      for (int i = 0; i < 3; i++) begin
         go(r, 1'b1);
         chk("stall_hold", em.alu_result, 32'd4);
         chk("stall_ready", 32'(ready), 32'd0);
      end
      go(r, 1'b0);
      chk("stall_rel", em.alu_result, 32'd5);

      r = mk(ALU_SRA, 32'h8000_0000, 32'd0, 5'd11);
      r.alu_src = 1'b1;
      r.imm = 32'd4;
      go(r, 1'b0);
      chk("sra", em.alu_result, 32'hF800_0000);
      go(mk(4'd13, 32'd5, 32'd7, 5'd12), 1'b0);
      chk("op13", em.alu_result, 32'd0);

      for (int i = 0; i < 11; i++) begin
         go(mk(t_op[i], t_a[i], t_b[i], 5'd13), 1'b0);
         chk("op_table", em.alu_result, t_exp[i]);
      end

      // stall in the redirect cycle
      go(mkbr(32'h300, 32'h40, 32'd6, 32'd6), 1'b0);
      chk("br2_rpc", rpc, 32'h340);
      go(g, 1'b1);
      chk("br2_pulse_stall", 32'(rv), 32'd0);
      go(g, 1'b0);
      chk("br2_sq", 32'(em.valid), 32'd0);
      go(g, 1'b0);
      chk("br2_after", 32'(em.valid), 32'd1);

      // back-to-back branches: the second is squashed
      go(mkbr(32'h400, 32'h10, 32'd1, 32'd1), 1'b0);
      go(mkbr(32'h500, 32'h10, 32'd1, 32'd1), 1'b0);
      chk("b2b_valid", 32'(em.valid), 32'd0);
      chk("b2b_rv", 32'(rv), 32'd0);
      go(g, 1'b0);
      chk("b2b_next_v", 32'(em.valid), 32'd1);
      chk("b2b_next_rv", 32'(rv), 32'd0);
      chk("b2b_rpc", rpc, 32'h410);

      // reset during a pending squash, with stall high
      go(mkbr(32'h600, 32'h4, 32'd2, 32'd2), 1'b0);
      rst = 1'b1;
      go(g, 1'b1);
      chk("mid_rst_v", 32'(em.valid), 32'd0);
      chk("mid_rst_alu", em.alu_result, 32'd0);
      chk("mid_rst_rv", 32'(rv), 32'd0);
      chk("mid_rst_rpc", rpc, 32'd0);
      rst = 1'b0;
      go(g, 1'b0);
      chk("post_rst_v", 32'(em.valid), 32'd1);
      chk("post_rst_alu", em.alu_result, 32'd2);

      go('0, 1'b0);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
